// File: rtl/pong_game_sequencer_if.sv
// Pong sequencer bus: scan position and widget coverage flags toward the
// sequencer, widget control strobes and score/status back out of it.
interface pong_game_sequencer_if;
  logic [10:0] X;
  logic [10:0] Y;
  logic        start;
  logic        ballYes;
  logic        leftYes;
  logic        rightYes;
  logic        ballEnable;
  logic        paddleEnable;
  logic        ballReset;
  logic        paddleHit;
  logic [3:0]  scoreLeft;
  logic [3:0]  scoreRight;
  logic        gameOver;
  logic [2:0]  state;

  modport master (
    output X, Y, start, ballYes, leftYes, rightYes,
    input  ballEnable, paddleEnable, ballReset, paddleHit,
    input  scoreLeft, scoreRight, gameOver, state
  );

  modport slave (
    input  X, Y, start, ballYes, leftYes, rightYes,
    output ballEnable, paddleEnable, ballReset, paddleHit,
    output scoreLeft, scoreRight, gameOver, state
  );
endinterface

// File: rtl/pong_game_sequencer.sv
// Frame-level pong controller: derives a once-per-frame tick from the scan
// position, latches ball/paddle/edge overlaps seen during the visible frame,
// and runs the serve/play/point/game-over sequence with saturating scores.
module pong_game_sequencer #(
  parameter int TICK_X       = 0,
  parameter int TICK_Y       = 600,
  parameter int RIGHT_EDGE   = 799,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90,
  parameter int WIN_SCORE    = 9
) (
  input  logic clk,
  input  logic reset,
  pong_game_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SERVE    = 3'd1,
    PLAY     = 3'd2,
    POINT    = 3'd3,
    GAMEOVER = 3'd4
  } state_t;

  localparam logic [10:0] TICK_X_C     = 11'(TICK_X);
  localparam logic [10:0] TICK_Y_C     = 11'(TICK_Y);
  localparam logic [10:0] RIGHT_C      = 11'(RIGHT_EDGE);
  localparam logic [10:0] VISIBLE_ROWS = 11'd600;
  localparam logic [7:0]  SERVE_LAST   = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0]  POINT_LAST   = 8'(POINT_FRAMES - 1);
  localparam logic [3:0]  WIN_C        = 4'(WIN_SCORE);

  logic       tickCond;
  logic       tick;
  logic       startRise;
  logic       tickCond_q;
  logic       start_q;
  logic       hitL_q;
  logic       hitR_q;
  logic       hitP_q;
  state_t     state_q;
  logic [7:0] frameCnt_q;
  logic [3:0] scoreLeft_q;
  logic [3:0] scoreRight_q;
  logic       ballEnable_q;
  logic       paddleEnable_q;
  logic       paddleHit_q;
  logic       ballReset_q;
  logic       gameOver_q;

  // A stalled scan position keeps tickCond high, so only its first cycle ticks.
  assign tickCond  = (bus.X == TICK_X_C) && (bus.Y == TICK_Y_C);
  assign tick      = tickCond && !tickCond_q;
  assign startRise = bus.start && !start_q;

  function automatic logic [3:0] satInc(input logic [3:0] s);
    return (s < WIN_C) ? s + 4'd1 : s;
  endfunction

  // One-cycle history of the tick condition and the start level for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tickCond_q <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      tickCond_q <= tickCond;
      start_q    <= bus.start;
    end
  end

  // Overlap events collected over the visible frame, consumed and cleared at the tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hitL_q <= 1'b0;
      hitR_q <= 1'b0;
      hitP_q <= 1'b0;
    end else if (tick) begin
      hitL_q <= 1'b0;
      hitR_q <= 1'b0;
      hitP_q <= 1'b0;
    end else if (bus.Y < VISIBLE_ROWS) begin
      if (bus.ballYes && (bus.X == 11'd0))                 hitL_q <= 1'b1;
      if (bus.ballYes && (bus.X == RIGHT_C))               hitR_q <= 1'b1;
      if (bus.ballYes && (bus.leftYes || bus.rightYes))    hitP_q <= 1'b1;
    end
  end

  // Game sequencer with registered strobes, ball reset level and scores.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      frameCnt_q     <= 8'd0;
      scoreLeft_q    <= 4'd0;
      scoreRight_q   <= 4'd0;
      ballEnable_q   <= 1'b0;
      paddleEnable_q <= 1'b0;
      paddleHit_q    <= 1'b0;
      ballReset_q    <= 1'b1;
      gameOver_q     <= 1'b0;
    end else begin
      ballEnable_q   <= 1'b0;
      paddleEnable_q <= 1'b0;
      paddleHit_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q      <= SERVE;
            scoreLeft_q  <= 4'd0;
            scoreRight_q <= 4'd0;
            frameCnt_q   <= 8'd0;
            ballReset_q  <= 1'b0;
          end
        end
        SERVE: begin
          if (tick) begin
            paddleEnable_q <= 1'b1;
            if (frameCnt_q == SERVE_LAST) begin
              state_q    <= PLAY;
              frameCnt_q <= 8'd0;
            end else begin
              frameCnt_q <= frameCnt_q + 8'd1;
            end
          end
        end
        PLAY: begin
          if (tick) begin
            paddleEnable_q <= 1'b1;
            ballEnable_q   <= 1'b1;
            paddleHit_q    <= hitP_q;
            if (hitL_q) begin
              scoreRight_q <= satInc(scoreRight_q);
              state_q      <= POINT;
              frameCnt_q   <= 8'd0;
              ballReset_q  <= 1'b1;
            end else if (hitR_q) begin
              scoreLeft_q  <= satInc(scoreLeft_q);
              state_q      <= POINT;
              frameCnt_q   <= 8'd0;
              ballReset_q  <= 1'b1;
            end
          end
        end
        POINT: begin
          if (tick) begin
            paddleEnable_q <= 1'b1;
            if (frameCnt_q == POINT_LAST) begin
              frameCnt_q <= 8'd0;
              if ((scoreLeft_q == WIN_C) || (scoreRight_q == WIN_C)) begin
                state_q    <= GAMEOVER;
                gameOver_q <= 1'b1;
              end else begin
                state_q     <= SERVE;
                ballReset_q <= 1'b0;
              end
            end else begin
              frameCnt_q <= frameCnt_q + 8'd1;
            end
          end
        end
        GAMEOVER: begin
          if (startRise) begin
            state_q      <= SERVE;
            scoreLeft_q  <= 4'd0;
            scoreRight_q <= 4'd0;
            frameCnt_q   <= 8'd0;
            gameOver_q   <= 1'b0;
            ballReset_q  <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          ballReset_q <= 1'b1;
          gameOver_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ballEnable   = ballEnable_q;
  assign bus.paddleEnable = paddleEnable_q;
  assign bus.paddleHit    = paddleHit_q;
  assign bus.ballReset    = ballReset_q;
  assign bus.gameOver     = gameOver_q;
  assign bus.scoreLeft    = scoreLeft_q;
  assign bus.scoreRight   = scoreRight_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_pong_game_sequencer.sv
// Bench for pong_game_sequencer: drives abstract frames (a few visible pixels,
// optional overlap events, a possibly stalled tick position) and compares every
// output on every cycle against a frame-level game model.
module tb_pong_game_sequencer;

  localparam int SERVE_N = 3;
  localparam int POINT_N = 4;
  localparam int WIN_N   = 3;
  localparam int RIGHT_X = 799;

  localparam int M_IDLE     = 0;
  localparam int M_SERVE    = 1;
  localparam int M_PLAY     = 2;
  localparam int M_POINT    = 3;
  localparam int M_GAMEOVER = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;

  pong_game_sequencer_if bus ();

  pong_game_sequencer #(
    .TICK_X      (0),
    .TICK_Y      (600),
    .RIGHT_EDGE  (RIGHT_X),
    .SERVE_FRAMES(SERVE_N),
    .POINT_FRAMES(POINT_N),
    .WIN_SCORE   (WIN_N)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int mode, sL, sR, frames;
  bit sawL, sawR, sawP, prevTc, prevSt;
  bit expBE, expPE, expPH;
  bit startLevel;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mode = M_IDLE; sL = 0; sR = 0; frames = 0;
    sawL = 0; sawR = 0; sawP = 0; prevTc = 0; prevSt = 0;
    expBE = 0; expPE = 0; expPH = 0;
  endtask

  // Game rules applied to one pixel-clock cycle of stimulus.
  task automatic modelStep(input int x, input int y, input bit st, input bit b,
                           input bit l, input bit r);
    bit tc, tk;
    tc = (x == 0) && (y == 600);
    tk = tc && !prevTc;
    prevTc = tc;
    expBE = 0; expPE = 0; expPH = 0;
    if (mode == M_IDLE && st) begin
      mode = M_SERVE; sL = 0; sR = 0; frames = 0;
    end else if (mode == M_GAMEOVER && st && !prevSt) begin
      mode = M_SERVE; sL = 0; sR = 0; frames = 0;
    end else if (tk) begin
      if (mode == M_SERVE) begin
        expPE = 1;
        frames++;
        if (frames == SERVE_N) begin mode = M_PLAY; frames = 0; end
      end else if (mode == M_PLAY) begin
        expPE = 1; expBE = 1; expPH = sawP;
        if (sawL) begin
          if (sR < WIN_N) sR++;
          mode = M_POINT; frames = 0;
        end else if (sawR) begin
          if (sL < WIN_N) sL++;
          mode = M_POINT; frames = 0;
        end
      end else if (mode == M_POINT) begin
        expPE = 1;
        frames++;
        if (frames == POINT_N) begin
          frames = 0;
          mode = (sL == WIN_N || sR == WIN_N) ? M_GAMEOVER : M_SERVE;
        end
      end
    end
    if (tk) begin
      sawL = 0; sawR = 0; sawP = 0;
    end else if (y < 600) begin
      if (b && x == 0)       sawL = 1;
      if (b && x == RIGHT_X) sawR = 1;
      if (b && (l || r))     sawP = 1;
    end
    prevSt = st;
  endtask

  task automatic checkAll();
    checkOutput("state",        int'(bus.state),        mode);
    checkOutput("scoreLeft",    int'(bus.scoreLeft),    sL);
    checkOutput("scoreRight",   int'(bus.scoreRight),   sR);
    checkOutput("ballReset",    int'(bus.ballReset),
                (mode == M_IDLE || mode == M_POINT || mode == M_GAMEOVER) ? 1 : 0);
    checkOutput("gameOver",     int'(bus.gameOver),     (mode == M_GAMEOVER) ? 1 : 0);
    checkOutput("ballEnable",   int'(bus.ballEnable),   int'(expBE));
    checkOutput("paddleEnable", int'(bus.paddleEnable), int'(expPE));
    checkOutput("paddleHit",    int'(bus.paddleHit),    int'(expPH));
  endtask

  task automatic applyStimulus(input int x, input int y, input bit st, input bit b,
                               input bit l, input bit r);
    bus.X = 11'(x); bus.Y = 11'(y); bus.start = st;
    bus.ballYes = b; bus.leftYes = l; bus.rightYes = r;
    modelStep(x, y, st, b, l, r);
    @(posedge clk);
    #1;
    checkAll();
  endtask

  // Noise pixels never create events; events are injected only when requested.
  task automatic runFrame(input int nVis, input bit evL, input bit evR, input bit evP,
                          input int stall);
    bit b, l, r;
    for (int i = 0; i < nVis; i++) begin
      b = ($urandom_range(0, 2) == 0);
      l = b ? 1'b0 : 1'($urandom_range(0, 1));
      r = b ? 1'b0 : 1'($urandom_range(0, 1));
      applyStimulus($urandom_range(1, 798), $urandom_range(0, 599), startLevel, b, l, r);
    end
    if (evL) applyStimulus(0, 100, startLevel, 1, 0, 0);
    if (evP) applyStimulus(780, 250, startLevel, 1, 1'($urandom_range(0, 1)), 1);
    if (evR) applyStimulus(RIGHT_X, 400, startLevel, 1, 0, 0);
    for (int i = 0; i < stall; i++) applyStimulus(0, 600, startLevel, 0, 0, 0);
    applyStimulus(5, 601, startLevel, 0, 0, 0);
  endtask

  initial begin
    int guard;
    bus.X = 0; bus.Y = 0; bus.start = 0;
    bus.ballYes = 0; bus.leftYes = 0; bus.rightYes = 0;
    startLevel = 0;
    modelReset();
    #12;
    checkAll();
    @(posedge clk); #1;
    reset = 1'b1;

    // Idle frames: events and ticks must not produce enables
    runFrame(3, 1, 1, 1, 1);
    runFrame(2, 0, 0, 0, 1);

    // One-cycle start, then serve frames into play
    applyStimulus(100, 50, 1, 0, 0, 0);
    checkOutput("startToServe", int'(bus.state), M_SERVE);
    repeat (SERVE_N) runFrame(3, 0, 0, 0, 1);
    checkOutput("serveToPlay", int'(bus.state), M_PLAY);

    // Left-edge hit scores for the right player
    runFrame(3, 1, 0, 0, 1);
    checkOutput("hitLscore", int'(bus.scoreRight), 1);
    checkOutput("hitLpoint", int'(bus.state), M_POINT);
    repeat (POINT_N) runFrame(2, 0, 0, 0, 1);
    checkOutput("pointToServe", int'(bus.state), M_SERVE);
    repeat (SERVE_N) runFrame(2, 0, 0, 0, 1);

    // Paddle hit: one pulse, no score change
    runFrame(3, 0, 0, 1, 1);
    checkOutput("paddleStay", int'(bus.state), M_PLAY);

    // Both edges in one frame: left has priority
    runFrame(2, 1, 1, 0, 1);
    checkOutput("bothRight", int'(bus.scoreRight), 2);
    checkOutput("bothLeft", int'(bus.scoreLeft), 0);

    // Right-edge hits until the left player wins; start held high across entry
    guard = 0;
    while (mode != M_GAMEOVER && guard < 200) begin
      if (mode == M_POINT && sL == WIN_N) startLevel = 1;
      runFrame(2, 0, (mode == M_PLAY), 0, 1);
      guard++;
    end
    checkOutput("reachGameOver", int'(bus.gameOver), 1);
    checkOutput("winScore", int'(bus.scoreLeft), WIN_N);
    repeat (3) runFrame(2, 0, 0, 0, 1);
    checkOutput("heldStartIgnored", int'(bus.state), M_GAMEOVER);
    startLevel = 0;
    applyStimulus(50, 601, 0, 0, 0, 0);
    applyStimulus(50, 601, 1, 0, 0, 0);
    checkOutput("restartServe", int'(bus.state), M_SERVE);
    checkOutput("restartScore", int'(bus.scoreLeft), 0);

    // Stalled tick position yields one tick per frame
    repeat (SERVE_N) runFrame(2, 0, 0, 0, 5);
    checkOutput("stallPlay", int'(bus.state), M_PLAY);

    // Asynchronous reset in the middle of play with a pending event
    applyStimulus(0, 300, 0, 1, 0, 0);
    #3;
    reset = 1'b0;
    #1;
    modelReset();
    checkAll();
    @(posedge clk); #1;
    checkAll();
    reset = 1'b1;
    runFrame(2, 0, 0, 0, 1);
    runFrame(2, 0, 0, 0, 1);

    // Randomized play
    for (int f = 0; f < 250; f++) begin
      startLevel = ($urandom_range(0, 5) == 0);
      runFrame($urandom_range(1, 4), ($urandom_range(0, 4) == 0),
               ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0),
               $urandom_range(1, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
